div_unit: RTL

Iterative RV32M divide unit: computes DIV, DIVU, REM and REMU one quotient bit per cycle with a radix-2 restoring algorithm. Sits beside the execute stage. Consumes the two register-file read ports (RD1/RD2 values) and drives the register-file write port (WE3/AD3/WD3) through a ready/valid writeback handshake with the main pipeline. While the unit is busy, the pipeline stalls.

---
 rtl/div_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Ports: clk, rst, start, op, rs1_val, rs2_val, rd, wb_ready -> busy, we, wa, wd.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd,
  input  logic        wb_ready,
  output logic        busy,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        sel_r_q, sel_r_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div0;
  logic        ovf;
  logic [32:0] rem_sh;
  logic [32:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] q_res;
  logic [31:0] r_res;

  always_comb begin
    sgn   = ~op[0];
    a_neg = sgn & rs1_val[31];
    b_neg = sgn & rs2_val[31];
    a_mag = a_neg ? (~rs1_val + 32'd1) : rs1_val;
    b_mag = b_neg ? (~rs2_val + 32'd1) : rs2_val;
    div0  = (rs2_val == 32'd0);
    ovf   = sgn & (rs1_val == 32'h8000_0000)
                & (rs2_val == 32'hFFFF_FFFF);

    // Restoring step: shift in next dividend bit, subtract if it fits.
    rem_sh = {rem_q[31:0], quo_q[31]};
    quo_nx = {quo_q[30:0], 1'b0};
    rem_nx = rem_sh;
    if (rem_sh >= {1'b0, dvs_q}) begin
      rem_nx    = rem_sh - {1'b0, dvs_q};
      quo_nx[0] = 1'b1;
    end
    q_res = neg_q_q ? (~quo_nx + 32'd1) : quo_nx;
    r_res = neg_r_q ? (~rem_nx[31:0] + 32'd1) : rem_nx[31:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sel_r_d = sel_r_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    rd_d    = rd_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_r_d = op[1];
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          rd_d    = rd;
          if (div0) begin
            wd_d    = op[1] ? rs1_val : 32'hFFFF_FFFF;
            wa_d    = rd;
            state_d = S_DONE;
          end else if (ovf) begin
            wd_d    = op[1] ? 32'd0 : 32'h8000_0000;
            wa_d    = rd;
            state_d = S_DONE;
          end else begin
            cnt_d   = 5'd0;
            rem_d   = 33'd0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          wd_d    = sel_r_q ? r_res : q_res;
          wa_d    = rd_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      sel_r_q <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      rd_q    <= 5'd0;
      wa_q    <= 5'd0;
      wd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sel_r_q <= sel_r_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      rd_q    <= rd_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  // Writes to x0 are suppressed; the handshake still completes.
  assign we   = (state_q == S_DONE) & wb_ready & (wa_q != 5'd0);
  assign wa   = wa_q;
  assign wd   = wd_q;

endmodule
